// File: rtl/dmem_wait_responder_pkg.sv
// Shared definitions for the data-memory wait-state responder.
//   state_t  : FSM state encoding (IDLE / WAITS / RESP)
//   CNT_W    : width of the wait-state down-counter
//   WORD_W   : data word width in bits
//   WORD_B   : bytes per word (one byte enable each)
package dmem_wait_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAITS = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam int CNT_W  = 4;
    localparam int WORD_W = 32;
    localparam int WORD_B = WORD_W / 8;

endpackage

// File: rtl/dmem_wait_responder_bram_be.sv
// Synchronous single-port word RAM with per-byte write enables.
//   clk_i    : clock
//   wen_i    : byte write enables, wen_i[i] writes wdata_i[8i+7:8i]
//   ren_i    : read enable, loads rdata_o on the rising edge
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : registered read data (holds between reads)
module bram_be
    import dmem_wait_responder_pkg::*;
#(
    parameter int AW   = 10,
    parameter     INIT = ""
) (
    input  logic              clk_i,
    input  logic [WORD_B-1:0] wen_i,
    input  logic              ren_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [2**AW];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < WORD_B; i++) begin
            if (wen_i[i]) begin
                mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (ren_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/dmem_wait_responder.sv
// Responder end of the CPU data-memory port with programmable wait states.
//   clk    : clock, rising edge
//   clr    : asynchronous active-high reset (RAM contents are kept)
//   req    : request valid, held by the CPU until ready
//   we     : 1 = store, 0 = load (sampled at accept)
//   addr   : byte address, addr[1:0] ignored
//   be     : store byte enables
//   wdata  : store data (sampled at accept)
//   ready  : one-cycle response strobe
//   rdata  : load data while ready, else 0
//   err    : out-of-range flag while ready, else 0
//   busy   : high while waiting or responding
module dmem_wait_responder
    import dmem_wait_responder_pkg::*;
#(
    parameter int AW   = 10,
    parameter int WAIT = 2,
    parameter     INIT = ""
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [WORD_B-1:0] be,
    input  logic [WORD_W-1:0] wdata,
    output logic              ready,
    output logic [WORD_W-1:0] rdata,
    output logic              err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_C    = CNT_W'(WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam bit               ZERO_WAIT = (WAIT == 0);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                we_q;
    logic [AW-1:0]       widx_q;
    logic [WORD_B-1:0]   be_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                oor_q;
    logic                ready_q;
    logic                err_q;
    logic                busy_q;
    logic                load_q;

    logic                oor_in;
    logic                enter_resp;
    logic                op_we;
    logic                op_oor;
    logic [AW-1:0]       op_idx;
    logic [WORD_B-1:0]   op_be;
    logic [WORD_W-1:0]   op_wdata;
    logic [WORD_B-1:0]   ram_wen;
    logic                ram_ren;
    logic [WORD_W-1:0]   ram_rdata;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];
    assign oor_in          = |addr[31:AW+2];

    // With zero wait states the RAM access happens on the accepting edge, so
    // the operands come straight from the port rather than the capture regs.
    assign op_we    = (state_q == S_IDLE) ? we          : we_q;
    assign op_oor   = (state_q == S_IDLE) ? oor_in      : oor_q;
    assign op_idx   = (state_q == S_IDLE) ? addr[AW+1:2] : widx_q;
    assign op_be    = (state_q == S_IDLE) ? be          : be_q;
    assign op_wdata = (state_q == S_IDLE) ? wdata       : wdata_q;

    // clr gates the RAM so an edge seen while reset is held never commits a store.
    assign enter_resp = !clr &&
                        ((state_q == S_IDLE  && req && ZERO_WAIT) ||
                         (state_q == S_WAITS && cnt_q == CNT_LAST));

    assign ram_wen = (enter_resp && op_we && !op_oor) ? op_be : '0;
    assign ram_ren =  enter_resp && !op_we && !op_oor;

    bram_be #(
        .AW   (AW),
        .INIT (INIT)
    ) u_ram (
        .clk_i   (clk),
        .wen_i   (ram_wen),
        .ren_i   (ram_ren),
        .addr_i  (op_idx),
        .wdata_i (op_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            widx_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    if (req) begin
                        we_q    <= we;
                        widx_q  <= addr[AW+1:2];
                        be_q    <= be;
                        wdata_q <= wdata;
                        oor_q   <= oor_in;
                        cnt_q   <= WAIT_C;
                        busy_q  <= 1'b1;
                        if (ZERO_WAIT) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            err_q   <= oor_in;
                            load_q  <= !we;
                        end else begin
                            state_q <= S_WAITS;
                        end
                    end
                end
                S_WAITS: begin
                    cnt_q <= cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        err_q   <= oor_q;
                        load_q  <= !we_q;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // RAM read register is not reset; gating keeps rdata at 0 outside a load response.
    assign rdata = (ready_q && load_q && !err_q) ? ram_rdata : '0;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: two instances (WAIT=2 and WAIT=0) checked
// against a byte-level memory model with per-byte validity tracking.
module tb_dmem_wait_responder;

    localparam int AW = 10;
    localparam int DEPTH = 2**AW;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_a   [2];
    logic        we_a    [2];
    logic [31:0] addr_a  [2];
    logic [3:0]  be_a    [2];
    logic [31:0] wdata_a [2];
    logic        ready_a [2];
    logic [31:0] rdata_a [2];
    logic        err_a   [2];
    logic        busy_a  [2];

    logic [31:0] mdl [2][DEPTH];
    logic [3:0]  vld [2][DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_wait_responder #(.AW(AW), .WAIT(2), .INIT("")) u_dut_w2 (
        .clk(clk), .clr(clr), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
        .be(be_a[0]), .wdata(wdata_a[0]), .ready(ready_a[0]), .rdata(rdata_a[0]),
        .err(err_a[0]), .busy(busy_a[0])
    );

    dmem_wait_responder #(.AW(AW), .WAIT(0), .INIT("")) u_dut_w0 (
        .clk(clk), .clr(clr), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
        .be(be_a[1]), .wdata(wdata_a[1]), .ready(ready_a[1]), .rdata(rdata_a[1]),
        .err(err_a[1]), .busy(busy_a[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Apply the architectural effect of a completed store to the model.
    task automatic mdl_store(input int d, input logic [31:0] a, input logic [3:0] b,
                             input logic [31:0] wd);
        int idx;
        if (a[31:AW+2] != 0) return;
        idx = int'(a[AW+1:2]);
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
                vld[d][idx][i] = 1'b1;
            end
        end
    endtask

    // One transaction: drive, scramble inputs after accept, check latency/busy/result.
    task automatic txn(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd, input bit rel_clr);
        logic        oor;
        int          idx;
        logic [31:0] exp_rd;
        bit          known;
        bit          got;
        int          k;
        int          wt;
        wt     = wait_of(d);
        oor    = (a[31:AW+2] != 0);
        idx    = int'(a[AW+1:2]);
        known  = oor || w || (vld[d][idx] == 4'hF);
        exp_rd = (!w && !oor) ? mdl[d][idx] : 32'h0;
        @(negedge clk);
        if (rel_clr) clr = 1'b0;
        req_a[d] = 1'b1; we_a[d] = w; addr_a[d] = a; be_a[d] = b; wdata_a[d] = wd;
        got = 0;
        k = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (ready_a[d]) begin
                got = 1;
                chk("latency", 32'(k), 32'(wt + 1));
                chk("busy_resp", 32'(busy_a[d]), 32'd1);
                chk("err", 32'(err_a[d]), 32'(oor));
                if (!w && known) chk("rdata", rdata_a[d], exp_rd);
                if (w) mdl_store(d, a, b, wd);
                req_a[d] = 1'b0;
            end else begin
                chk("busy_wait", 32'(busy_a[d]), 32'd1);
                chk("rdata_idle", rdata_a[d], 32'h0);
            end
            if (k == 1) begin
                we_a[d] = $urandom_range(0, 1) != 0;
                addr_a[d] = $urandom;
                be_a[d] = 4'($urandom);
                wdata_a[d] = $urandom;
            end
        end
        if (!got) begin
            chk("timeout", 32'd0, 32'd1);
            req_a[d] = 1'b0;
        end
        @(negedge clk);
        chk("ready_after", 32'(ready_a[d]), 32'd0);
        chk("busy_after", 32'(busy_a[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] da [3];
        logic        dw [3];
        logic [3:0]  db [3];
        logic [31:0] exp_load;
        int          nready;
        int          cur;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld[d][i] = 4'h0;
                mdl[d][i] = 32'h0;
            end
            req_a[d] = 1'b0; we_a[d] = 1'b0; addr_a[d] = 32'h0;
            be_a[d] = 4'h0; wdata_a[d] = 32'h0;
        end

        // Reset held with requests pending: nothing may respond.
        clr = 1'b1;
        req_a[0] = 1'b1; req_a[1] = 1'b1; be_a[0] = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_ready", 32'(ready_a[d]), 32'd0);
                chk("rst_busy", 32'(busy_a[d]), 32'd0);
                chk("rst_rdata", rdata_a[d], 32'h0);
                chk("rst_err", 32'(err_a[d]), 32'd0);
            end
        end
        req_a[1] = 1'b0;
        txn(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);

        // Known contents for the working window (words 0..15 and the top word).
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i <= 16; i++) begin
                int wi;
                wi = (i == 16) ? DEPTH - 1 : i;
                txn(d, 1'b1, 32'(wi) << 2, 4'hF, $urandom, 1'b0);
            end
        end

        // Full-word store then load.
        txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        chk("model_full", mdl[0][4], 32'hDEADBEEF);

        // Byte-enable merge and the empty-mask no-op.
        txn(0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, 1'b0);
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        txn(0, 1'b1, 32'h12, 4'b0000, 32'h12345678, 1'b0);
        txn(0, 1'b0, 32'h13, 4'hF, 32'h0, 1'b0);
        chk("model_be", mdl[0][4], 32'hDEADAAEF);

        // Out-of-range: flagged, no aliasing onto word 0.
        txn(0, 1'b1, 32'h00001000, 4'hF, 32'hCAFEF00D, 1'b0);
        txn(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h00001000, 4'hF, 32'h0, 1'b0);

        // Zero wait states, req held across three requests.
        da[0] = 32'h8;  dw[0] = 1'b1; db[0] = 4'hF;
        da[1] = 32'hC;  dw[1] = 1'b1; db[1] = 4'($urandom);
        da[2] = 32'h8;  dw[2] = 1'b0; db[2] = 4'hF;
        cur = 0;
        nready = 0;
        @(negedge clk);
        req_a[1] = 1'b1; we_a[1] = dw[0]; addr_a[1] = da[0]; be_a[1] = db[0];
        wdata_a[1] = 32'hA5A50001;
        exp_load = 32'hA5A50001;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(ready_a[1]), 32'((c <= 5) && (c % 2 == 1)));
            if (ready_a[1]) begin
                nready++;
                if (!dw[cur]) chk("b2b_rdata", rdata_a[1], exp_load);
                else mdl_store(1, da[cur], db[cur], wdata_a[1]);
                cur++;
                if (cur < 3) begin
                    we_a[1] = dw[cur]; addr_a[1] = da[cur]; be_a[1] = db[cur];
                    wdata_a[1] = 32'h5A5A0002;
                end else begin
                    req_a[1] = 1'b0;
                end
            end
        end
        chk("b2b_count", 32'(nready), 32'd3);

        // Reset during the wait phase of a store aborts it.
        @(negedge clk);
        req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 32'h20; be_a[0] = 4'hF;
        wdata_a[0] = 32'h55555555;
        @(negedge clk);
        chk("abort_busy", 32'(busy_a[0]), 32'd1);
        clr = 1'b1;
        req_a[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_ready", 32'(ready_a[0]), 32'd0);
            chk("abort_busy_rst", 32'(busy_a[0]), 32'd0);
        end
        txn(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b1);

        // Randomized traffic on both instances.
        for (int n = 0; n < 200; n++) begin
            int          d;
            int          sel;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
                if (a[31:AW+2] == 0) a[AW+2] = 1'b1;
            end else begin
                sel = int'($urandom_range(0, 16));
                a = (32'((sel == 16) ? DEPTH - 1 : sel) << 2) | 32'($urandom_range(0, 3));
            end
            txn(d, $urandom_range(0, 1) != 0, a, 4'($urandom), $urandom, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
